alu_dispatch: RTL

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Request FIFO (4 deep) in front of an external combinational ALU, with one output response register.
// Optional macro ALU_DISPATCH_STATS_EN adds the op_count response counter port.
module alu_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_op1,
    input  logic [15:0] req_op2,
    input  logic [3:0]  req_alu_op,
    input  logic [3:0]  req_tag,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    output logic [3:0]  alu_op_code,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic [3:0]  rsp_tag,
    output logic        rsp_illegal
`ifdef ALU_DISPATCH_STATS_EN
    ,output logic [15:0] op_count
`endif
);
    logic [15:0] r_op1 [0:3];
    logic [15:0] r_op2 [0:3];
    logic [3:0]  r_op  [0:3];
    logic [3:0]  r_tag [0:3];
    logic [1:0]  r_wptr, r_rptr;
    logic [2:0]  r_count;

    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    logic        r_rsp_zero;
    logic [3:0]  r_rsp_tag;
    logic        r_rsp_illegal;

    logic w_empty, w_full, w_push, w_pop;

    assign w_empty   = (r_count == 3'd0);
    assign w_full    = (r_count == 3'd4);
    // Ready depends only on occupancy, so a full FIFO refuses even when it pops this edge.
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = !w_empty && (!r_rsp_valid || rsp_ready);

    assign alu_op1     = w_empty ? 16'd0 : r_op1[r_rptr];
    assign alu_op2     = w_empty ? 16'd0 : r_op2[r_rptr];
    assign alu_op_code = w_empty ? 4'd0  : r_op[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op1[r_wptr] <= req_op1;
            r_op2[r_wptr] <= req_op2;
            r_op[r_wptr]  <= req_alu_op;
            r_tag[r_wptr] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= 16'd0;
            r_rsp_zero    <= 1'b0;
            r_rsp_tag     <= 4'd0;
            r_rsp_illegal <= 1'b0;
        end else if (w_pop) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= alu_result;
            r_rsp_zero    <= alu_zero;
            r_rsp_tag     <= r_tag[r_rptr];
            r_rsp_illegal <= (r_op[r_rptr] > 4'd8);
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_illegal = r_rsp_illegal;

`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] r_op_count;
    always_ff @(posedge clk) begin
        if (rst)
            r_op_count <= 16'd0;
        else if (r_rsp_valid && rsp_ready && (r_op_count != 16'hFFFF))
            r_op_count <= r_op_count + 16'd1;
    end
    assign op_count = r_op_count;
`endif
endmodule
